// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word memory that answers the pipeline data port and stalls it meanwhile
// Ports:
//   clk_i            clock, all state on rising edge
//   rst_i            asynchronous active-low reset (array contents are kept)
//   req_i            request valid, held with its fields stable until ack_o
//   we_i             1 = store, 0 = load
//   addr_i           byte address (word aligned, below DEPTH_WORDS*4 to be legal)
//   wdata_i          store data
//   rdata_o          load data, nonzero only while ack_o=1
//   ack_o            single-cycle completion pulse
//   err_o            completion with error (misaligned or out of range), only while ack_o=1
//   stall_o          pipeline freeze while a request is being accepted or is in flight
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        stall_o
);
   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t state, state_nx;
   logic [3:0] cnt;
   logic we_q, err_q, commit;
   logic [IW-1:0] idx_q;
   logic [31:0] wdata_q, rdata_q;
   logic [31:0] mem [DEPTH_WORDS];
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = (state == IDLE) ? (req_i ? BUSY : IDLE)
               : (state == BUSY) ? ((cnt == 4'd0) ? RESP : BUSY)
               : IDLE;
      commit  = (state == BUSY) && (cnt == 4'd0);
      ack_o   = (state == RESP);
      err_o   = ack_o & err_q;
      rdata_o = ack_o ? rdata_q : 32'd0;
      // stall must read 0 during reset even though req_i may still be high
      stall_o = rst_i & ((state == IDLE) ? req_i : (state == BUSY));
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         if (state == IDLE && req_i) begin
            we_q    <= we_i;
            idx_q   <= addr_i[IW+1:2];
            wdata_q <= wdata_i;
            // upper address bits are only needed for the range check, so decide the error now
            err_q   <= (addr_i[1:0] != 2'b00) | ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));
            cnt     <= 4'(LATENCY - 1);
         end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (commit) rdata_q <= (we_q || err_q) ? 32'd0 : mem[idx_q];
      end
   end
   // no reset on the array; a store cut off by reset never reaches commit because state is IDLE
   always_ff @(posedge clk_i) begin
      if (commit && we_q && !err_q) mem[idx_q] <= wdata_q;
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven, hand-sequenced and randomized checks of data_mem_responder
// Ports: none (drives a LATENCY=3 instance and a LATENCY=1 instance from one clock/reset)
module tb_data_mem_responder;
   localparam int LAT = 3;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req = 1'b0, we = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
   logic ack, err, stall;
   logic r1_req = 1'b0, r1_we = 1'b0;
   logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0, r1_rdata;
   logic r1_ack, r1_err, r1_stall;
   int n_cmp = 0, n_bad = 0;
   logic [31:0] mdl [256];
   bit known [256];
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        e;
   } vec_t;
   vec_t tv [10];
   always #5 clk = ~clk;
   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
      .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .rdata_o(rdata), .ack_o(ack), .err_o(err), .stall_o(stall)
   );
   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst_n), .req_i(r1_req), .we_i(r1_we), .addr_i(r1_addr), .wdata_i(r1_wdata),
      .rdata_o(r1_rdata), .ack_o(r1_ack), .err_o(r1_err), .stall_o(r1_stall)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask
   function automatic bit exp_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
   endfunction
   task automatic upd(input logic w, input logic [31:0] a, input logic [31:0] d);
      if (w && !exp_err(a)) begin
         mdl[a[9:2]] = d;
         known[a[9:2]] = 1'b1;
      end
   endtask
   // one full request: counts stall cycles, finds the ack cycle, checks the cycle after RESP
   task automatic run_txn(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit scramble, input bit chk_rd, input logic [31:0] exp_rd, input logic exp_e);
      logic [31:0] rd;
      logic e;
      int lat, st;
      @(posedge clk); #1;
      req = 1'b1; we = w; addr = a; wdata = d;
      lat = -1; st = 0; rd = 32'd0; e = 1'b0;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         @(negedge clk);
         if (stall) st++;
         if (ack) begin lat = k; rd = rdata; e = err; end
         @(posedge clk); #1;
         if (scramble && k == 0) begin
            req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom;
         end
      end
      req = 1'b0;
      chk({nm, " ack cycle"}, 32'(lat), LAT + 1);
      chk({nm, " stall cycles"}, 32'(st), LAT + 1);
      chk({nm, " err"}, {31'd0, e}, {31'd0, exp_e});
      if (chk_rd) chk({nm, " rdata"}, rd, exp_rd);
      @(negedge clk);
      chk({nm, " post-resp ack/err/stall/rdata"}, {29'd0, ack, err, stall} | rdata, 32'd0);
   endtask
   initial begin
      tv[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
      tv[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      tv[2] = '{1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
      tv[3] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      tv[4] = '{1'b1, 32'h0,   32'h0BADF00D, 32'h0,        1'b0};
      tv[5] = '{1'b1, 32'h3FC, 32'h11223344, 32'h0,        1'b0};
      tv[6] = '{1'b1, 32'h400, 32'h55667788, 32'h0,        1'b1};
      tv[7] = '{1'b0, 32'h0,   32'h0,        32'h0BADF00D, 1'b0};
      tv[8] = '{1'b0, 32'h3FC, 32'h0,        32'h11223344, 1'b0};
      tv[9] = '{1'b1, 32'h20,  32'hAAAA0000, 32'h0,        1'b0};
      // reset state, with req held high to show stall is forced low
      req = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset outputs", {29'd0, ack, err, stall} | rdata, 32'd0);
      chk("reset outputs lat1", {29'd0, r1_ack, r1_err, r1_stall} | r1_rdata, 32'd0);
      req = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         run_txn($sformatf("tbl%0d", i), tv[i].we, tv[i].addr, tv[i].wdata, 1'b0, 1'b1, tv[i].rd, tv[i].e);
         upd(tv[i].we, tv[i].addr, tv[i].wdata);
      end
      // req dropped and fields scrambled right after acceptance
      run_txn("drop", 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
      // reset in the middle of a store: the store must be lost
      @(posedge clk); #1;
      req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234;
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy stall", {31'd0, stall}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async reset outputs", {29'd0, ack, err, stall} | rdata, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      chk("reset held stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      req = 1'b0; rst_n = 1'b1;
      begin
         int acks = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack || stall) acks++;
         end
         chk("no completion after reset", 32'(acks), 32'd0);
      end
      run_txn("after reset load", 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'hAAAA0000, 1'b0);
      // LATENCY=1: store, load, misaligned load back to back with req held throughout
      @(posedge clk); #1;
      for (int c = 0; c < 10; c++) begin
         r1_req = (c < 9); r1_we = (c < 3);
         r1_addr = (c < 6) ? 32'h14 : 32'h15; r1_wdata = 32'hCAFEF00D;
         @(negedge clk);
         chk($sformatf("lat1 ack c%0d", c), {31'd0, r1_ack}, {31'd0, (c < 9) && (c % 3 == 2)});
         chk($sformatf("lat1 stall c%0d", c), {31'd0, r1_stall}, {31'd0, (c < 9) && (c % 3 != 2)});
         if (c == 5) chk("lat1 load rdata", r1_rdata, 32'hCAFEF00D);
         if (c == 8) chk("lat1 misaligned err/rdata", {31'd0, r1_err} | r1_rdata, 32'd1);
         @(posedge clk); #1;
      end
      r1_req = 1'b0;
      // randomized traffic against the array model
      for (int i = 0; i < 60; i++) begin
         logic w;
         logic [31:0] a, d;
         logic e;
         int sel;
         sel = $urandom_range(0, 5);
         w = 1'($urandom);
         d = $urandom;
         a = (sel <= 2) ? {25'd0, 3'($urandom), 2'b00}
           : (sel == 3) ? {25'd0, 5'($urandom), 2'($urandom_range(1, 3))}
           : (sel == 4) ? ($urandom | 32'h400) & 32'hFFFFFFFC
           : 32'h3FC;
         e = exp_err(a);
         run_txn($sformatf("rnd%0d", i), w, a, d, 1'($urandom), w || e || known[a[9:2]],
                 (w || e) ? 32'd0 : mdl[a[9:2]], e);
         upd(w, a, d);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
